// File: rtl/rmw_long_latency_pkg.sv
// Shared types and sizing for the long-latency read-modify-write table responder.
// Provides id/word/tag types, the in-flight tag budget, the default table size
// and the responder FSM state encoding.
package rmw_long_latency_pkg;

    localparam int unsigned ID_W        = 16;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned IN_FLIGHT_N = 16;
    localparam int unsigned TAG_W       = $clog2(IN_FLIGHT_N);
    localparam int unsigned TBL_N_DEF   = 256;
    localparam int unsigned TBL_W_DEF   = $clog2(TBL_N_DEF);

    typedef logic [ID_W-1:0]      id_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [TBL_W_DEF-1:0] tbl_idx_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/rmw_tbl_ram.sv
// Table storage: one synchronous write port, one read port.
// No reset on the array; contents are established by the responder's INIT sweep.
// Same-address write/read collisions are resolved by the responder's bypass.
// Ports:
//   clk      - clock
//   we       - write enable
//   waddr    - write index
//   wdata    - write word
//   raddr    - read index
//   rdata_c  - read word (combinational from the array)
module rmw_tbl_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port
    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/rmw_tbl_responder.sv
// Fixed-latency table lookup responder with writeback port.
// After reset the table is swept to zero (busy). Accepted lookups travel a
// LATENCY-deep pipeline and read the table in the last stage; the response is
// registered from that read, with a bypass for a same-cycle write to the index.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   lk_vld/lk_rdy/lk_id/lk_tag - lookup request handshake and payload
//   rsp_vld/rsp_tag/rsp_data   - response (no backpressure)
//   wr_vld/wr_rdy/wr_id/wr_data- writeback handshake and payload
//   busy                       - table initialisation in progress
//   err_dup_tag                - sticky: lookup accepted with tag already in flight
module rmw_tbl_responder
    import rmw_long_latency_pkg::*;
#(
    parameter int unsigned LATENCY = 20,
    parameter int unsigned TBL_N   = TBL_N_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  lk_vld,
    output logic  lk_rdy,
    input  id_t   lk_id,
    input  tag_t  lk_tag,
    output logic  rsp_vld,
    output tag_t  rsp_tag,
    output word_t rsp_data,
    input  logic  wr_vld,
    output logic  wr_rdy,
    input  id_t   wr_id,
    input  word_t wr_data,
    output logic  busy,
    output logic  err_dup_tag
);

    localparam int unsigned TBL_W = $clog2(TBL_N);
    localparam int unsigned CNT_W = TAG_W + 1;
    localparam int unsigned LAST  = LATENCY - 1;

    state_e                        state_q, state_d;
    logic [TBL_W-1:0]              init_cnt_q, init_cnt_d;
    logic [LATENCY-1:0]            pipe_vld_q, pipe_vld_d;
    tag_t [LATENCY-1:0]            pipe_tag_q, pipe_tag_d;
    logic [LATENCY-1:0][TBL_W-1:0] pipe_idx_q, pipe_idx_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [IN_FLIGHT_N-1:0]        tag_vec_q, tag_vec_d;
    logic                          err_q, err_d;
    logic                          lk_rdy_q, lk_rdy_d;
    logic                          wr_rdy_q, wr_rdy_d;
    logic                          busy_q, busy_d;
    logic                          rsp_vld_q, rsp_vld_d;
    tag_t                          rsp_tag_q, rsp_tag_d;
    word_t                         rsp_data_q, rsp_data_d;

    logic             lk_acc_c, wr_acc_c, dup_c, byp_c;
    logic [TBL_W-1:0] lk_idx_c, wr_idx_c;
    logic             ram_we_c;
    logic [TBL_W-1:0] ram_waddr_c;
    word_t            ram_wdata_c, ram_rdata_c;
    logic             unused_id_bits;

    assign lk_idx_c       = lk_id[TBL_W-1:0];
    assign wr_idx_c       = wr_id[TBL_W-1:0];
    assign unused_id_bits = ^{lk_id[ID_W-1:TBL_W], wr_id[ID_W-1:TBL_W]};

    rmw_tbl_ram #(
        .DEPTH (TBL_N),
        .AW    (TBL_W),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_c),
        .waddr   (ram_waddr_c),
        .wdata   (ram_wdata_c),
        .raddr   (pipe_idx_q[LAST]),
        .rdata_c (ram_rdata_c)
    );

    // Next-state, table write mux, in-flight tracking, pipeline and response
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = init_cnt_q;
        ram_wdata_c = '0;
        cnt_d       = cnt_q;
        tag_vec_d   = tag_vec_q;

        // Handshakes are qualified by the registered ready flags
        lk_acc_c = lk_vld & lk_rdy_q;
        wr_acc_c = wr_vld & wr_rdy_q;

        unique case (state_q)
            ST_INIT: begin
                ram_we_c   = 1'b1;
                init_cnt_d = init_cnt_q + TBL_W'(1);
                if (init_cnt_q == TBL_W'(TBL_N - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                ram_we_c    = wr_acc_c;
                ram_waddr_c = wr_idx_c;
                ram_wdata_c = wr_data;
            end
            default: state_d = ST_INIT;
        endcase

        unique case ({lk_acc_c, rsp_vld_q})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // A tag retiring this cycle may be reissued without flagging a duplicate
        dup_c = lk_acc_c & tag_vec_q[lk_tag] & ~(rsp_vld_q & (rsp_tag_q == lk_tag));
        err_d = err_q | dup_c;

        if (rsp_vld_q) begin
            tag_vec_d[rsp_tag_q] = 1'b0;
        end
        if (lk_acc_c) begin
            tag_vec_d[lk_tag] = 1'b1;
        end

        pipe_vld_d = {pipe_vld_q[LATENCY-2:0], lk_acc_c};
        pipe_tag_d = {pipe_tag_q[LATENCY-2:0], lk_tag};
        pipe_idx_d = {pipe_idx_q[LATENCY-2:0], lk_idx_c};

        // Write landing on the same edge as the final-stage read wins
        byp_c      = wr_acc_c & (state_q == ST_READY) & (wr_idx_c == pipe_idx_q[LAST]);
        rsp_vld_d  = pipe_vld_q[LAST];
        rsp_tag_d  = pipe_vld_q[LAST] ? pipe_tag_q[LAST] : '0;
        rsp_data_d = '0;
        if (pipe_vld_q[LAST]) begin
            rsp_data_d = byp_c ? wr_data : ram_rdata_c;
        end

        // Ready flags registered from next-state so they track the current count
        lk_rdy_d = (state_d == ST_READY) && (cnt_d < CNT_W'(IN_FLIGHT_N));
        wr_rdy_d = (state_d == ST_READY);
        busy_d   = (state_d == ST_INIT);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
            pipe_idx_q <= '0;
            cnt_q      <= '0;
            tag_vec_q  <= '0;
            err_q      <= 1'b0;
            lk_rdy_q   <= 1'b0;
            wr_rdy_q   <= 1'b0;
            busy_q     <= 1'b1;
            rsp_vld_q  <= 1'b0;
            rsp_tag_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_tag_q <= pipe_tag_d;
            pipe_idx_q <= pipe_idx_d;
            cnt_q      <= cnt_d;
            tag_vec_q  <= tag_vec_d;
            err_q      <= err_d;
            lk_rdy_q   <= lk_rdy_d;
            wr_rdy_q   <= wr_rdy_d;
            busy_q     <= busy_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign lk_rdy      = lk_rdy_q;
    assign wr_rdy      = wr_rdy_q;
    assign busy        = busy_q;
    assign err_dup_tag = err_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_rmw_tbl_responder.sv
// Scoreboard bench for rmw_tbl_responder: expected responses are queued at
// lookup acceptance and matched against DUT responses (tag, data, latency).
module tb_rmw_tbl_responder;
    import rmw_long_latency_pkg::*;

    localparam int LAT = 20;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  lk_vld, lk_rdy;
    id_t   lk_id;
    tag_t  lk_tag;
    logic  rsp_vld;
    tag_t  rsp_tag;
    word_t rsp_data;
    logic  wr_vld, wr_rdy;
    id_t   wr_id;
    word_t wr_data;
    logic  busy, err_dup_tag;

    rmw_tbl_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lk_vld      (lk_vld),
        .lk_rdy      (lk_rdy),
        .lk_id       (lk_id),
        .lk_tag      (lk_tag),
        .rsp_vld     (rsp_vld),
        .rsp_tag     (rsp_tag),
        .rsp_data    (rsp_data),
        .wr_vld      (wr_vld),
        .wr_rdy      (wr_rdy),
        .wr_id       (wr_id),
        .wr_data     (wr_data),
        .busy        (busy),
        .err_dup_tag (err_dup_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;
    int last_acc = 0;

    typedef struct {
        tag_t       tg;
        logic [7:0] idx;
        int         due;
    } exp_t;

    exp_t  sb_q[$];
    word_t tbl_m[256];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every response must match the oldest queued lookup
    always @(negedge clk) begin : mon
        exp_t e;
        if (rsp_vld !== 1'b0) begin
            if (sb_q.size() == 0) begin
                check_eq("unexp_rsp", 64'(rsp_vld), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check_eq("rsp_tag", 64'(rsp_tag), 64'(e.tg));
                check_eq("rsp_data", 64'(rsp_data), 64'(tbl_m[e.idx]));
                check_eq("rsp_lat", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic do_lookup(input id_t id, input tag_t tg);
        int n = 0;
        @(negedge clk);
        while (lk_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (lk_rdy !== 1'b1) begin
            check_eq("lk_rdy_timeout", 64'(lk_rdy), 64'(1));
            return;
        end
        lk_vld   = 1'b1;
        lk_id    = id;
        lk_tag   = tg;
        last_acc = cyc + 1;
        sb_q.push_back('{tg: tg, idx: id[7:0], due: cyc + 1 + LAT});
        @(posedge clk);
        #1 lk_vld = 1'b0;
    endtask

    task automatic do_write(input id_t id, input word_t data);
        int n = 0;
        @(negedge clk);
        while (wr_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (wr_rdy !== 1'b1) begin
            check_eq("wr_rdy_timeout", 64'(wr_rdy), 64'(1));
            return;
        end
        wr_vld  = 1'b1;
        wr_id   = id;
        wr_data = data;
        @(posedge clk);
        tbl_m[id[7:0]] = data;
        #1 wr_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(sb_q.size()), 64'(0));
    endtask

    // Reset, then verify the INIT sweep length and ready flags
    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 256; i++) tbl_m[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_flags", 64'({busy, lk_rdy, wr_rdy, rsp_vld, err_dup_tag}), 64'(5'b10000));
        check_eq("rst_rsp", 64'({rsp_tag, rsp_data}), 64'(0));
        rst_n = 1'b1;
        for (int k = 1; k < 256; k++) begin
            @(negedge clk);
            check_eq("init_flags", 64'({busy, lk_rdy, wr_rdy}), 64'(3'b100));
        end
        @(negedge clk);
        check_eq("ready_flags", 64'({busy, lk_rdy, wr_rdy}), 64'(3'b011));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a;
        int n;
        rst_n   = 1'b1;
        lk_vld  = 1'b0;
        lk_id   = '0;
        lk_tag  = '0;
        wr_vld  = 1'b0;
        wr_id   = '0;
        wr_data = '0;
        #2;
        do_reset();

        // Freshly zeroed table
        do_lookup(16'h0005, 4'd0);
        wait_drain();

        // Write then read back, including upper id bits that must be ignored
        do_write(16'h0012, 32'hDEADBEEF);
        do_lookup(16'h0012, 4'd3);
        do_lookup(16'hAB12, 4'd4);
        wait_drain();

        // Fill all 16 in-flight slots back to back
        for (int t = 0; t < 16; t++) do_lookup(id_t'($urandom_range(0, 16'hFFFF)), tag_t'(t));
        @(negedge clk);
        check_eq("lk_rdy_full", 64'(lk_rdy), 64'(0));
        n = 0;
        while (rsp_vld !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("first_rsp", 64'(rsp_vld), 64'(1));
        check_eq("lk_rdy_at_rsp", 64'(lk_rdy), 64'(0));
        @(negedge clk);
        check_eq("lk_rdy_after_rsp", 64'(lk_rdy), 64'(1));
        wait_drain();

        // Write accepted 19 cycles after the lookup
        do_lookup(16'h0040, 4'd1);
        a = last_acc;
        while (cyc < a + 17) @(negedge clk);
        do_write(16'h0040, 32'h11);
        wait_drain();

        // Write accepted on the same edge the response registers (bypass)
        do_lookup(16'h0041, 4'd2);
        a = last_acc;
        while (cyc < a + 18) @(negedge clk);
        do_write(16'h0041, 32'h22);
        wait_drain();

        // Tag retired and reissued on the same cycle is legal
        check_eq("err_clean", 64'(err_dup_tag), 64'(0));
        do_lookup(16'h0005, 4'd9);
        a = last_acc;
        while (cyc < a + 19) @(negedge clk);
        do_lookup(16'h0006, 4'd9);
        wait_drain();
        check_eq("err_retire_reissue", 64'(err_dup_tag), 64'(0));

        // Duplicate tag in flight sets sticky error; both still respond
        do_lookup(16'h0007, 4'd7);
        do_lookup(16'h0008, 4'd7);
        @(negedge clk);
        check_eq("err_dup", 64'(err_dup_tag), 64'(1));
        wait_drain();
        check_eq("err_sticky", 64'(err_dup_tag), 64'(1));

        // Reset with lookups in flight: no responses, table re-zeroed
        for (int t = 0; t < 5; t++) do_lookup(id_t'($urandom_range(0, 16'hFFFF)), tag_t'(t));
        do_reset();
        check_eq("err_after_rst", 64'(err_dup_tag), 64'(0));
        do_lookup(16'h0012, 4'd3);
        wait_drain();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
